// File: rtl/seq_alu.sv
// seq_alu: multi-cycle 16-bit ALU; 1-cycle logic/add/sub, 16-step shift-add MUL.
// Define SEQ_ALU_DIV_EN to make op 7 a restoring divide instead of MOV.
module seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             neg,
   output logic             carry
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, mcand, mul_acc;
   logic [WIDTH-1:0]   mplier, fin_res, w_res;
   logic [WIDTH:0]     sc;
   logic               iter_op, fin_carry, w_carry, wr;
`ifdef SEQ_ALU_DIV_EN
   logic               div_q, ge;
   logic [WIDTH:0]     rem_sh, rem_n;
   logic [WIDTH-1:0]   q_n;
`endif
   assign busy = state == ITER;
   assign done = state == DONE;
   always_comb begin
      case (op)
         3'd0:    sc = {1'b0, a} + {1'b0, b};
         3'd1:    sc = {1'b0, a} - {1'b0, b};
         3'd2:    sc = {1'b0, a & b};
         3'd3:    sc = {1'b0, a | b};
         3'd4:    sc = {1'b0, a ^ b};
         3'd5:    sc = {1'b0, ~a};
         3'd7:    sc = {1'b0, b};
         default: sc = '0;
      endcase
   end
   assign mul_acc = mplier[0] ? acc + mcand : acc;
`ifdef SEQ_ALU_DIV_EN
   // Remainder lives in acc, dividend shifts out of mplier while quotient bits shift in.
   assign iter_op   = op[2] & op[1];
   assign rem_sh    = {acc[WIDTH-1:0], mplier[WIDTH-1]};
   assign ge        = rem_sh >= {1'b0, mcand[WIDTH-1:0]};
   assign rem_n     = ge ? rem_sh - {1'b0, mcand[WIDTH-1:0]} : rem_sh;
   assign q_n       = {mplier[WIDTH-2:0], ge};
   assign fin_res   = div_q ? q_n : mul_acc[WIDTH-1:0];
   assign fin_carry = div_q ? ~|mcand[WIDTH-1:0] : |mul_acc[2*WIDTH-1:WIDTH];
`else
   assign iter_op   = op == 3'd6;
   assign fin_res   = mul_acc[WIDTH-1:0];
   assign fin_carry = |mul_acc[2*WIDTH-1:WIDTH];
`endif
   assign w_res   = busy ? fin_res : sc[WIDTH-1:0];
   assign w_carry = busy ? fin_carry : sc[WIDTH];
   assign wr      = busy ? cnt == CW'(WIDTH - 1) : start & ~iter_op;
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         result <= '0;
         zero   <= 1'b0;
         neg    <= 1'b0;
         carry  <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
         div_q  <= 1'b0;
`endif
      end else begin
         if (wr) begin
            result <= w_res;
            carry  <= w_carry;
            zero   <= w_res == '0;
            neg    <= w_res[WIDTH-1];
         end
         if (busy) begin
            cnt <= cnt + 1'b1;
            state <= wr ? DONE : ITER;
`ifdef SEQ_ALU_DIV_EN
            if (div_q) begin
               acc    <= {{(WIDTH-1){1'b0}}, rem_n};
               mplier <= q_n;
            end else begin
               acc    <= mul_acc;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
            end
`else
            acc    <= mul_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
`endif
         end else if (start && iter_op) begin
            state <= ITER;
            cnt   <= '0;
            acc   <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= op[0];
            mcand  <= {{WIDTH{1'b0}}, op[0] ? b : a};
            mplier <= op[0] ? a : b;
`else
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
`endif
         end else begin
            state <= start ? DONE : IDLE;
         end
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed-vector bench for seq_alu with immediate-assertion checks.
module tb_seq_alu;
   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [15:0] a = '0, b = '0;
   logic        busy, done, zero, neg, carry;
   logic [15:0] result;
   int vectors = 0;
   int errs = 0;

   seq_alu dut (.CLK(CLK), .reset(reset), .start(start), .op(op), .a(a), .b(b),
                .busy(busy), .done(done), .result(result), .zero(zero), .neg(neg), .carry(carry));

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic flags(input string tag, input logic [15:0] r, input logic z, input logic n, input logic c);
      chk({tag, ".result"}, result, r);
      chk({tag, ".zero"}, 16'(zero), 16'(z));
      chk({tag, ".neg"}, 16'(neg), 16'(n));
      chk({tag, ".carry"}, 16'(carry), 16'(c));
   endtask

   task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      op = o; a = x; b = y; start = 1'b1;
      @(negedge CLK);
   endtask

   // Issues an iterative op, pokes an ignored ADD mid-run, counts busy cycles.
   task automatic iter_run(input string tag, input logic [2:0] o, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] r, input logic c);
      int n = 0;
      issue(o, x, y);
      start = 1'b0;
      while (busy && n < 40) begin
         start = (n == 3);
         if (n == 3) begin op = 3'd0; a = 16'h1111; b = 16'h2222; end
         n++;
         @(negedge CLK);
      end
      start = 1'b0;
      chk({tag, ".busy_cycles"}, 16'(n), 16'd16);
      chk({tag, ".done"}, 16'(done), 16'd1);
      flags(tag, r, r == 16'h0, r[15], c);
      @(negedge CLK);
      chk({tag, ".no_extra_done"}, 16'(done), 16'd0);
      chk({tag, ".hold"}, result, r);
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      flags("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("reset.done", 16'(done), 16'd0);
      chk("reset.busy", 16'(busy), 16'd0);
      reset = 1'b0;
      @(negedge CLK);

      issue(3'd0, 16'hFFFF, 16'h0001);
      chk("add.done", 16'(done), 16'd1);
      flags("add", 16'h0000, 1'b1, 1'b0, 1'b1);

      issue(3'd1, 16'h0003, 16'h0005);
      flags("sub", 16'hFFFE, 1'b0, 1'b1, 1'b1);
      issue(3'd4, 16'h00FF, 16'h0F0F);
      chk("xor.done", 16'(done), 16'd1);
      flags("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
      issue(3'd2, 16'hF0F0, 16'h0FF0);
      flags("and", 16'h00F0, 1'b0, 1'b0, 1'b0);
      issue(3'd3, 16'hF000, 16'h000F);
      flags("or", 16'hF00F, 1'b0, 1'b1, 1'b0);
      issue(3'd5, 16'h00FF, 16'h1234);
      flags("not", 16'hFF00, 1'b0, 1'b1, 1'b0);
      start = 1'b0;
      @(negedge CLK);
      chk("idle.done", 16'(done), 16'd0);
      chk("idle.hold", result, 16'hFF00);

      iter_run("mul1", 3'd6, 16'h0123, 16'h0045, 16'h4E6F, 1'b0);
      iter_run("mul2", 3'd6, 16'h0100, 16'h0100, 16'h0000, 1'b1);

      issue(3'd6, 16'h0003, 16'h0004);
      start = 1'b0;
      repeat (7) @(negedge CLK);
      chk("midreset.busy_before", 16'(busy), 16'd1);
      #2 reset = 1'b1;
      #1;
      chk("midreset.busy", 16'(busy), 16'd0);
      chk("midreset.done", 16'(done), 16'd0);
      flags("midreset", 16'h0000, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      issue(3'd0, 16'h0002, 16'h0002);
      start = 1'b0;
      chk("add2.done", 16'(done), 16'd1);
      flags("add2", 16'h0004, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);

`ifdef SEQ_ALU_DIV_EN
      iter_run("div", 3'd7, 16'h0064, 16'h0007, 16'h000E, 1'b0);
      iter_run("div0", 3'd7, 16'h0064, 16'h0000, 16'hFFFF, 1'b1);
`else
      issue(3'd7, 16'h0064, 16'h0007);
      start = 1'b0;
      chk("mov.done", 16'(done), 16'd1);
      flags("mov", 16'h0007, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
